// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver and its transmitter sibling.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Majority samples sit at OVERSAMPLE/2 - MAJ_OFFSET .. OVERSAMPLE/2 + MAJ_OFFSET
    localparam int MAJ_OFFSET = 1;

    function automatic int calc_div(input int clk_khz, input int baud, input int os);
        longint num;
        longint den;
        num = longint'(clk_khz) * 64'sd1000;
        den = longint'(baud) * longint'(os);
        return int'(num / den);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Output word handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 break_o;
    logic                 overrun_o;

    modport master (
        output data_o, valid_o, parity_err_o, frame_err_o, break_o, overrun_o,
        input  ready_i
    );

    modport slave (
        input  data_o, valid_o, parity_err_o, frame_err_o, break_o, overrun_o,
        output ready_i
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks while enabled, held at 0 otherwise.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_KHZ    = 100000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic en_i,
    output logic tick_o
);
    localparam int DIV = calc_div(CLK_KHZ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_baud_tick: clock too slow for BAUD*OVERSAMPLE");
        end
    endgenerate

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else if (!en_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, error flags and valid/ready output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_KHZ    = 100000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic rx_i,
    output logic busy_o,
    uart_rx_os_if.master rx_if
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam parity_e PAR_MODE = parity_e'(PARITY);
    localparam logic [CW-1:0] SAMP_FIRST = CW'(OVERSAMPLE / 2 - MAJ_OFFSET);
    localparam logic [CW-1:0] SAMP_MID   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SAMP_LAST  = CW'(OVERSAMPLE / 2 + MAJ_OFFSET);
    localparam logic [CW-1:0] SCNT_MAX   = CW'(OVERSAMPLE - 1);

    generate
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_rx_os: illegal parameter combination");
        end
    endgenerate

    logic                 sync1_q, rx_s_q;
    rx_state_e            state_q;
    logic [CW-1:0]        scnt_q;
    logic                 samp_a_q, samp_b_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q, ferr_q;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_q, frame_q, brk_q, ovr_q;

    logic tick, decide, bit_val, complete, exp_par, perr_d, ferr_d, brk_d;

    uart_baud_tick #(
        .CLK_KHZ    (CLK_KHZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .en_i    (state_q != ST_IDLE),
        .tick_o  (tick)
    );

    assign decide   = tick && (scnt_q == SAMP_LAST);
    assign bit_val  = maj3(samp_a_q, samp_b_q, rx_s_q);
    assign complete = (state_q == ST_STOP) && decide && (stop_cnt_q == 1'(STOP_BITS - 1));
    assign exp_par  = (PAR_MODE == PAR_ODD) ? ~^shift_q : ^shift_q;
    assign perr_d   = (PAR_MODE != PAR_NONE) && (par_bit_q != exp_par);
    assign ferr_d   = ferr_q | ~bit_val;
    assign brk_d    = ferr_d && (shift_q == '0) && ((PAR_MODE == PAR_NONE) || !par_bit_q);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= ST_IDLE;
            scnt_q     <= '0;
            samp_a_q   <= 1'b1;
            samp_b_q   <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
            if (state_q == ST_IDLE) begin
                scnt_q <= '0;
            end else if (tick) begin
                scnt_q <= (scnt_q == SCNT_MAX) ? '0 : scnt_q + CW'(1);
            end
            if (tick && scnt_q == SAMP_FIRST) samp_a_q <= rx_s_q;
            if (tick && scnt_q == SAMP_MID)   samp_b_q <= rx_s_q;
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q  <= '0;
                    stop_cnt_q <= 1'b0;
                    ferr_q     <= 1'b0;
                    if (!rx_s_q) state_q <= ST_START;
                end
                ST_START: if (decide) begin
                    // A start bit that votes high was noise: drop silently
                    state_q <= bit_val ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (decide) begin
                    shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_q <= (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
                ST_PARITY: if (decide) begin
                    par_bit_q <= bit_val;
                    state_q   <= ST_STOP;
                end
                ST_STOP: if (decide) begin
                    ferr_q <= ferr_d;
                    // Leave at the last stop vote so the next start edge is caught early
                    if (complete) state_q <= ST_IDLE;
                    else          stop_cnt_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            frame_q <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || rx_if.ready_i) begin
                    data_q  <= shift_q;
                    perr_q  <= perr_d;
                    frame_q <= ferr_d;
                    brk_q   <= brk_d;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_if.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.data_o       = data_q;
    assign rx_if.valid_o      = valid_q;
    assign rx_if.parity_err_o = perr_q;
    assign rx_if.frame_err_o  = frame_q;
    assign rx_if.break_o      = brk_q;
    assign rx_if.overrun_o    = ovr_q;
    assign busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three configurations share one serial line.
module tb_uart_rx_os;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic busy_a, busy_b, busy_c;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os_if #(.DATA_BITS(8)) ifa ();
    uart_rx_os_if #(.DATA_BITS(8)) ifb ();
    uart_rx_os_if #(.DATA_BITS(8)) ifc ();

    uart_rx_os #(.CLK_KHZ(16000), .BAUD(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(1), .STOP_BITS(1))
        dut_a (.clk_i(clk), .arst_ni(rst_n), .rx_i(rx), .busy_o(busy_a), .rx_if(ifa.master));
    uart_rx_os #(.CLK_KHZ(16000), .BAUD(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1))
        dut_b (.clk_i(clk), .arst_ni(rst_n), .rx_i(rx), .busy_o(busy_b), .rx_if(ifb.master));
    uart_rx_os #(.CLK_KHZ(16000), .BAUD(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(1), .STOP_BITS(2))
        dut_c (.clk_i(clk), .arst_ni(rst_n), .rx_i(rx), .busy_o(busy_c), .rx_if(ifc.master));

    // Monitors: record every accepted word, overrun pulses and valid activity
    word_t obs_a_mem [64];
    int    obs_a_wr = 0;
    int    ovr_a = 0;
    int    hi_a = 0;
    int    rise_a = 0;
    logic  prev_va = 1'b0;
    word_t last_b, last_c;
    int    cnt_b = 0;
    int    cnt_c = 0;

    always @(negedge clk) begin
        if (ifa.valid_o && ifa.ready_i) begin
            obs_a_mem[obs_a_wr] <= word_t'({ifa.data_o, ifa.parity_err_o, ifa.frame_err_o, ifa.break_o});
            obs_a_wr <= obs_a_wr + 1;
        end
        if (ifa.overrun_o) ovr_a <= ovr_a + 1;
        if (ifa.valid_o) hi_a <= hi_a + 1;
        if (ifa.valid_o && !prev_va) rise_a <= cyc;
        prev_va <= ifa.valid_o;
        if (ifb.valid_o && ifb.ready_i) begin
            last_b <= word_t'({ifb.data_o, ifb.parity_err_o, ifb.frame_err_o, ifb.break_o});
            cnt_b  <= cnt_b + 1;
        end
        if (ifc.valid_o && ifc.ready_i) begin
            last_c <= word_t'({ifc.data_o, ifc.parity_err_o, ifc.frame_err_o, ifc.break_o});
            cnt_c  <= cnt_c + 1;
        end
    end

    word_t exp_a [$];
    int    rd_a = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] fr(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        return {4'b1111, s2, s1, p, d, 1'b0};
    endfunction

    // 16 clocks per bit; optionally invert one clock inside bit gbit at offset goff
    task automatic send_bits(input logic [15:0] bits, input int n, input int gbit, input int goff);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < 16; c++) begin
                rx = bits[b] ^ ((b == gbit) && (c == goff));
                step(1);
            end
        end
        rx = 1'b1;
    endtask

    task automatic drain_a();
        word_t e;
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            if (rd_a < obs_a_wr) begin
                check("wordA", 32'(obs_a_mem[rd_a]), 32'(e));
                rd_a++;
            end else begin
                check("wordA_missing", 32'(obs_a_wr - rd_a), 32'd1);
            end
        end
        check("wordA_extra", 32'(obs_a_wr - rd_a), 32'd0);
        rd_a = obs_a_wr;
    endtask

    initial begin
        int c0, h0, cb, cc, o0, lat;
        ifa.ready_i = 1'b1;
        ifb.ready_i = 1'b1;
        ifc.ready_i = 1'b1;
        #2;
        check("reset_outputs", 32'({busy_a, ifa.valid_o, ifa.data_o, ifa.parity_err_o,
                                     ifa.frame_err_o, ifa.break_o, ifa.overrun_o}), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(8);

        // 1: clean frame, latency and single-cycle valid
        h0 = hi_a;
        c0 = cyc;
        exp_a.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0, bk: 1'b0});
        send_bits(fr(8'hA5, 1'b0, 1'b1, 1'b1), 11, -1, 0);
        step(64);
        drain_a();
        lat = rise_a - c0;
        check("latency_window", 32'((lat >= 171) && (lat <= 175)), 32'd1);
        check("valid_one_cycle", 32'(hi_a - h0), 32'd1);

        // 2: parity bit 1 on 0x3C: even receiver flags it, odd receiver accepts
        cb = cnt_b;
        exp_a.push_back('{d: 8'h3C, pe: 1'b1, fe: 1'b0, bk: 1'b0});
        send_bits(fr(8'h3C, 1'b1, 1'b1, 1'b1), 11, -1, 0);
        step(64);
        drain_a();
        check("odd_count", 32'(cnt_b - cb), 32'd1);
        check("odd_word", 32'(last_b), 32'({8'h3C, 3'b000}));

        // 3: low stop bit, then line held low for 12 bits (break, then an all-ones frame)
        exp_a.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b1, bk: 1'b0});
        send_bits(fr(8'h5A, 1'b0, 1'b0, 1'b1), 11, -1, 0);
        step(64);
        drain_a();
        exp_a.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, bk: 1'b1});
        exp_a.push_back('{d: 8'hFF, pe: 1'b1, fe: 1'b0, bk: 1'b0});
        rx = 1'b0;
        step(12 * 16);
        rx = 1'b1;
        step(20 * 16);
        drain_a();

        // 4: false start, then glitch rejected by majority, then a clean follow-up
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(2);
        check("busy_false_start", 32'(busy_a), 32'd1);
        step(30);
        check("busy_after_false_start", 32'(busy_a), 32'd0);
        drain_a();
        exp_a.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0, bk: 1'b0});
        send_bits(fr(8'h81, 1'b0, 1'b1, 1'b1), 11, 4, 9);
        step(64);
        exp_a.push_back('{d: 8'h42, pe: 1'b0, fe: 1'b0, bk: 1'b0});
        send_bits(fr(8'h42, 1'b0, 1'b1, 1'b1), 11, -1, 0);
        step(64);
        drain_a();

        // 5: overrun while the consumer stalls
        ifa.ready_i = 1'b0;
        o0 = ovr_a;
        exp_a.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0, bk: 1'b0});
        send_bits(fr(8'h11, 1'b0, 1'b1, 1'b1), 11, -1, 0);
        step(64);
        send_bits(fr(8'h22, 1'b0, 1'b1, 1'b1), 11, -1, 0);
        step(64);
        check("overrun_pulses", 32'(ovr_a - o0), 32'd1);
        check("held_data", 32'(ifa.data_o), 32'h11);
        check("held_valid", 32'(ifa.valid_o), 32'd1);
        ifa.ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_drop", 32'(ifa.valid_o), 32'd0);
        step(1);
        drain_a();

        // 6: async reset in the middle of data bit 4, then two-stop frame with second stop low
        ifa.ready_i = 1'b0;
        send_bits(fr(8'h77, 1'b0, 1'b1, 1'b1), 11, -1, 0);
        step(64);
        check("pre_reset_valid", 32'(ifa.valid_o), 32'd1);
        send_bits(fr(8'h99, 1'b0, 1'b1, 1'b1), 5, -1, 0);
        rx = 1'b1;
        step(8);
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame", 32'({busy_a, ifa.valid_o, ifa.data_o, ifa.parity_err_o,
                                       ifa.frame_err_o, ifa.break_o, ifa.overrun_o}), 32'd0);
        step(3);
        rst_n = 1'b1;
        ifa.ready_i = 1'b1;
        step(64);
        cc = cnt_c;
        exp_a.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0, bk: 1'b0});
        exp_a.push_back('{d: 8'hFF, pe: 1'b1, fe: 1'b0, bk: 1'b0});
        send_bits(fr(8'hC3, 1'b0, 1'b1, 1'b0), 12, -1, 0);
        step(16 * 16);
        drain_a();
        check("two_stop_count", 32'(cnt_c - cc), 32'd1);
        check("two_stop_word", 32'(last_c), 32'({8'hC3, 3'b010}));
        check("overrun_total", 32'(ovr_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
